// File: rtl/regbank_arbiter_2ch.sv
// Two-client round-robin arbiter and sequencer for the 16x8 register bank.
// Every output is a register. A grant in IDLE drives the bank strobe in the next cycle.
// Reads pass through WAIT so the bank's registered Data_out can be captured.
module regbank_arbiter_2ch #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata1,
   output logic              bank_rd,
   output logic              bank_wr,
   output logic [ADDR_W-1:0] bank_addr,
   output logic [DATA_W-1:0] bank_din,
   input  logic [DATA_W-1:0] bank_dout,
   output logic              busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   logic [1:0] state_q, state_d;
   logic       last_q;   // client granted most recently
   logic       cur_q;    // client owning the current transaction
   logic       we_q;     // latched op of the current transaction
   logic       any_req;
   logic       win;
   logic       win_we;

   // Round-robin pick: a tie goes to the client that was not granted last
   always_comb begin
      any_req = req0 | req1;
      win     = req1 & (~req0 | ~last_q);
      win_we  = win ? we1 : we0;
   end

   // Next-state decode
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (any_req) state_d = ISSUE;
         ISSUE:   state_d = we_q ? RESP : WAIT;
         WAIT:    state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, latched request fields and all registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         cur_q     <= 1'b0;
         we_q      <= 1'b0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         rdata0    <= '0;
         rdata1    <= '0;
         bank_rd   <= 1'b0;
         bank_wr   <= 1'b0;
         bank_addr <= '0;
         bank_din  <= '0;
         busy      <= 1'b0;
      end else begin
         state_q <= state_d;
         busy    <= (state_d != IDLE);
         // Strobes and acks are single-cycle pulses
         ack0    <= 1'b0;
         ack1    <= 1'b0;
         bank_rd <= 1'b0;
         bank_wr <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (any_req) begin
                  cur_q     <= win;
                  last_q    <= win;
                  we_q      <= win_we;
                  bank_addr <= win ? addr1 : addr0;
                  if (win_we) bank_din <= win ? wdata1 : wdata0;
                  bank_wr   <= win_we;
                  bank_rd   <= ~win_we;
               end
            end
            ISSUE: begin
               if (we_q) begin
                  ack0 <= ~cur_q;
                  ack1 <= cur_q;
               end
            end
            WAIT: begin
               // Bank registered Data_out at the end of ISSUE; it is stable now
               if (cur_q) rdata1 <= bank_dout;
               else       rdata0 <= bank_dout;
               ack0 <= ~cur_q;
               ack1 <= cur_q;
            end
            RESP: begin
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regbank_arbiter_2ch.sv
// Directed bench for regbank_arbiter_2ch with a behavioural 16x8 register bank.
module tb_regbank_arbiter_2ch;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [3:0] addr0 = '0, addr1 = '0;
   logic [7:0] wdata0 = '0, wdata1 = '0;
   logic       ack0, ack1, bank_rd, bank_wr, busy;
   logic [7:0] rdata0, rdata1, bank_din;
   logic [7:0] bank_dout = '0;
   logic [3:0] bank_addr;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] mem [16] = '{5: 8'h5A, 6: 8'hA5, 9: 8'h99, default: 8'h00};

   regbank_arbiter_2ch #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
      .bank_rd(bank_rd), .bank_wr(bank_wr), .bank_addr(bank_addr), .bank_din(bank_din),
      .bank_dout(bank_dout), .busy(busy)
   );

   always #5 clk = ~clk;

   // Register bank model: write and registered read on the rising edge
   always @(posedge clk) begin
      if (bank_wr) mem[bank_addr] <= bank_din;
      if (bank_rd) bank_dout <= mem[bank_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset state
      #3;
      check("rst_ack0", ack0, 0);
      check("rst_ack1", ack1, 0);
      check("rst_rdata0", rdata0, 0);
      check("rst_rdata1", rdata1, 0);
      check("rst_strobes", {bank_rd, bank_wr}, 0);
      check("rst_addr", bank_addr, 0);
      check("rst_din", bank_din, 0);
      check("rst_busy", busy, 0);
      #9 reset = 1'b0;
      tick();

      // Reset asserted mid-ISSUE of a write
      req0 = 1; we0 = 1; addr0 = 4'd2; wdata0 = 8'h33;
      tick();
      check("abort_issue_wr", bank_wr, 1);
      #2 reset = 1'b1;
      #1;
      check("abort_wr_drop", bank_wr, 0);
      check("abort_busy", busy, 0);
      check("abort_addr", bank_addr, 0);
      check("abort_din", bank_din, 0);
      req0 = 0;
      #1 reset = 1'b0;
      tick();
      check("abort_no_ack", ack0, 0);
      check("abort_idle", busy, 0);

      // Tie after reset: client 0 writes 3<=81, client 1 reads 3
      req0 = 1; we0 = 1; addr0 = 4'd3; wdata0 = 8'h81;
      req1 = 1; we1 = 0; addr1 = 4'd3;
      tick();
      check("tie_wr", bank_wr, 1);
      check("tie_rd", bank_rd, 0);
      check("tie_addr", bank_addr, 3);
      check("tie_din", bank_din, 8'h81);
      tick();
      check("tie_ack0", ack0, 1);
      check("tie_ack1_lo", ack1, 0);
      req0 = 0;
      tick();
      check("tie_gap_idle", busy, 0);
      tick();
      check("tie_rd1", bank_rd, 1);
      check("tie_rd1_addr", bank_addr, 3);
      tick();
      check("tie_wait_ack1", ack1, 0);
      tick();
      check("tie_ack1", ack1, 1);
      check("tie_rdata1", rdata1, 8'h81);
      check("tie_rdata0_keep", rdata0, 0);
      req1 = 0;
      tick();

      // Client 0 write 8<=18 then read it back
      req0 = 1; we0 = 1; addr0 = 4'd8; wdata0 = 8'h18;
      tick();
      check("w8_wr", bank_wr, 1);
      check("w8_addr", bank_addr, 8);
      check("w8_din", bank_din, 8'h18);
      tick();
      check("w8_ack", ack0, 1);
      check("w8_wr_lo", bank_wr, 0);
      req0 = 0;
      tick();
      req0 = 1; we0 = 0; addr0 = 4'd8;
      tick();
      check("r8_rd", bank_rd, 1);
      check("r8_wr_lo", bank_wr, 0);
      tick();
      check("r8_wait_ack", ack0, 0);
      check("r8_wait_rd", bank_rd, 0);
      tick();
      check("r8_ack", ack0, 1);
      check("r8_rdata", rdata0, 8'h18);
      req0 = 0;
      tick();

      // Isolation: client 1 reads 5, then client 0 reads 6 with addr0 changed after grant
      req1 = 1; we1 = 0; addr1 = 4'd5;
      tick();
      tick();
      tick();
      check("r5_ack1", ack1, 1);
      check("r5_rdata1", rdata1, 8'h5A);
      req1 = 0;
      tick();
      req0 = 1; we0 = 0; addr0 = 4'd6;
      tick();
      addr0 = 4'd9;
      #1;
      check("r6_addr_latched", bank_addr, 6);
      tick();
      tick();
      check("r6_ack0", ack0, 1);
      check("r6_ack1_lo", ack1, 0);
      check("r6_rdata0", rdata0, 8'hA5);
      check("r6_rdata1_held", rdata1, 8'h5A);
      req0 = 0;
      tick();

      // Late request: req1 rises during client 0's WAIT
      req0 = 1; we0 = 0; addr0 = 4'd6;
      tick();
      tick();
      req1 = 1; we1 = 1; addr1 = 4'd10; wdata1 = 8'h77;
      tick();
      check("late_ack0", ack0, 1);
      check("late_ack1_lo", ack1, 0);
      req0 = 0;
      tick();
      check("late_idle", busy, 0);
      check("late_no_strobe", bank_wr, 0);
      tick();
      check("late_wr1", bank_wr, 1);
      check("late_addr1", bank_addr, 10);
      check("late_din1", bank_din, 8'h77);
      tick();
      check("late_ack1", ack1, 1);
      req1 = 0;
      tick();

      // Continuous contention: both writing; last grant was client 1, so order 0,1,0,1,0,1
      req0 = 1; we0 = 1; addr0 = 4'd12; wdata0 = 8'hC0;
      req1 = 1; we1 = 1; addr1 = 4'd13; wdata1 = 8'hD1;
      for (int t = 0; t < 6; t++) begin
         check("cc_idle", busy, 0);
         tick();
         check("cc_issue_addr", bank_addr, (t % 2 == 0) ? 12 : 13);
         check("cc_one_strobe", {bank_rd, bank_wr}, 2'b01);
         tick();
         check("cc_ack0", ack0, (t % 2 == 0) ? 1 : 0);
         check("cc_ack1", ack1, (t % 2 == 1) ? 1 : 0);
         if (t == 5) begin
            req0 = 0;
            req1 = 0;
         end
         tick();
      end
      tick();
      check("end_idle", busy, 0);
      check("end_mem12", mem[12], 8'hC0);
      check("end_mem13", mem[13], 8'hD1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/regbank_arbiter_2ch.md
Name: regbank_arbiter_2ch

Overview:
Two-requester arbiter and sequencer for the 16x8 register bank (RD/WR/address/data_in/Data_out).
It accepts read/write requests from two independent clients and grants the bank to one at a time using round-robin.
It drives the bank's strobes and address, captures the bank's registered read data, and returns an ack with data to the winning client.
It sits between the two datapath clients and the register bank instance.

Parameters:
DATA_W, 8, data width of bank and client buses
ADDR_W, 4, bank address width (16 entries)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
req0  input  1  client 0 request (level)
we0  input  1  client 0 op: 1=write, 0=read
addr0  input  ADDR_W  client 0 address
wdata0  input  DATA_W  client 0 write data
ack0  output  1  client 0 completion pulse (1 cycle)
rdata0  output  DATA_W  client 0 read data, valid with ack0, held until next read ack0
req1, we1, addr1, wdata1, ack1, rdata1  same as client 0, for client 1
bank_rd  output  1  to bank RD
bank_wr  output  1  to bank WR
bank_addr  output  ADDR_W  to bank address
bank_din  output  DATA_W  to bank data_in
bank_dout  input  DATA_W  from bank Data_out (registered on the clk edge where RD is sampled)
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async): state=IDLE. All outputs 0: ack*, rdata*, bank_rd, bank_wr, bank_addr, bank_din, busy. Round-robin pointer last=1, so client 0 wins the first tie.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant that client.
  - If both are high, grant the client != last.
  - On grant: latch we/addr/wdata of the winner, set last=winner, go to ISSUE.
- ISSUE (1 cycle):
  - bank_addr=latched addr.
  - Write: bank_wr=1, bank_din=latched wdata, next state RESP.
  - Read: bank_rd=1, next state WAIT.
  - Exactly one strobe is high. Strobes are 0 in every other state.
- WAIT (read only, 1 cycle): bank samples RD at the end of ISSUE. At the end of WAIT, capture bank_dout into the winner's rdata register. Next state RESP.
- RESP (1 cycle):
  - Winner's ack=1. Non-winner's ack stays 0.
  - On read, rdata of the winner updates and the other client's rdata is unchanged.
  - Next state IDLE.
- Latency, counted from the IDLE cycle in which the request is seen (cycle 0):
  - Write: strobe in cycle 1, ack in cycle 2.
  - Read: strobe in cycle 1, ack and data in cycle 3.
- Client rule: hold req/we/addr/wdata stable until ack. Fields are latched at grant, so later changes are ignored. Deassert req on the edge where ack is high. A req still high in the IDLE cycle after ack is a new request.
- Back-to-back: one transaction per pass through IDLE. There is a minimum of 1 IDLE cycle between transactions.
- Fairness: under continuous requests from both clients, grants strictly alternate 0,1,0,1. A requester waits at most one full transaction of the other client.
- A req arriving while busy is held pending. It is arbitrated at the next IDLE.
- Same-address write then read (either client) returns the newly written value.
- Reset mid-transaction: the transaction is aborted with no ack. Strobes drop immediately. A write in ISSUE is not guaranteed to land. rdata registers clear.
- Address wrap is not applicable: addresses 0..15 map directly. Address width mismatch is a configuration error, not handled at runtime.

Test Plan:
- Reset: assert reset mid-ISSUE of a write -> bank_wr drops same cycle, all outputs 0, state IDLE, no ack; after release, first tie grants client 0.
- Single write/read:
  - Client 0 write addr=8, wdata=8'h18 -> bank_wr=1, bank_addr=8, bank_din=8'h18 in cycle 1; ack0 in cycle 2.
  - Then read addr=8 -> bank_rd in cycle 1; ack0 with rdata0=8'h18 in cycle 3.
- Simultaneous requests from reset: client 0 writes addr=3 data 8'h81, client 1 reads addr=3 -> client 0 is granted first, client 1 next, ack1 with rdata1=8'h81.
- Continuous contention:
  - Both reqs held high for 6 transactions -> grant order 0,1,0,1,0,1.
  - No ack is ever on both ports in the same cycle.
  - bank_rd and bank_wr are never high together.
- Hold/isolation:
  - Client 1 reads addr=5 (=8'h5A), then client 0 reads addr=6 (=8'hA5) -> rdata1 stays 8'h5A after ack0, and rdata0=8'hA5.
  - Changing addr0 after grant does not alter bank_addr.
- Late request: req1 rises during client 0's WAIT -> it is granted in the IDLE cycle after ack0, and its strobe follows one cycle later.
